// File: rtl/block_data_memory_if.sv
// Request/response bundle between the cache controller (master) and the block data memory (slave).
interface block_data_memory_if #(
    parameter int WORD        = 32,
    parameter int ADDRESSL    = 15,
    parameter int BLOCK_WORDS = 4
);
    logic                        reqValid;
    logic                        reqWrite;
    logic [ADDRESSL-1:0]         reqAddress;
    logic [WORD-1:0]             writeData;
    logic                        reqReady;
    logic                        respValid;
    logic [WORD-1:0]             dataOut;
    logic [BLOCK_WORDS*WORD-1:0] blockOut;
    logic                        busy;

    modport master (
        output reqValid, reqWrite, reqAddress, writeData,
        input  reqReady, respValid, dataOut, blockOut, busy
    );

    modport slave (
        input  reqValid, reqWrite, reqAddress, writeData,
        output reqReady, respValid, dataOut, blockOut, busy
    );
endinterface

// File: rtl/block_data_memory.sv
// Backing store below the cache: word read, word write, or aligned block read per request,
// with a fixed accept-to-response latency and a valid/ready handshake.
module block_data_memory #(
    parameter int WORD        = 32,
    parameter int ADDRESSL    = 15,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rstN,
    block_data_memory_if.slave bus
);
    localparam int LENGTH = 1 << ADDRESSL;
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDRESSL-1:0] BASE_MASK = ~ADDRESSL'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                           state;
    logic [CW-1:0]                    counter;
    logic                             write_q;
    logic [ADDRESSL-1:0]              addr_q;
    logic [WORD-1:0]                  data_q;

    logic                             fire;
    logic                             cur_write;
    logic [ADDRESSL-1:0]              cur_addr;
    logic [WORD-1:0]                  cur_data;
    logic [ADDRESSL-1:0]              base;
    logic [WORD-1:0]                  rd_word;
    logic [BLOCK_WORDS-1:0][WORD-1:0] blk_rd;

    // Words are stored XORed with their own address, so a zero-initialised array reads back
    // as memory[i] = i without any preload, and reset never touches the contents.
    logic [WORD-1:0] mem [LENGTH];

    // With LATENCY=1 the response edge is the accept edge, so the live inputs are used directly.
    assign cur_write = (state == IDLE) ? bus.reqWrite   : write_q;
    assign cur_addr  = (state == IDLE) ? bus.reqAddress : addr_q;
    assign cur_data  = (state == IDLE) ? bus.writeData  : data_q;
    assign fire      = rstN && (((state == IDLE) && bus.reqValid && (LATENCY == 1)) ||
                                ((state == WAIT) && (counter == '0)));

    assign base    = cur_addr & BASE_MASK;
    assign rd_word = mem[cur_addr] ^ WORD'(cur_addr);

    for (genvar k = 0; k < BLOCK_WORDS; k++) begin : g_word
        logic [ADDRESSL-1:0] a;
        assign a         = base | ADDRESSL'(k);
        assign blk_rd[k] = mem[a] ^ WORD'(a);
    end

    always_ff @(posedge clk) begin
        if (fire && cur_write)
            mem[cur_addr] <= cur_data ^ WORD'(cur_addr);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            counter       <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            bus.reqReady  <= 1'b1;
            bus.respValid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.dataOut   <= '0;
            bus.blockOut  <= '0;
        end else begin
            bus.respValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.reqValid) begin
                        write_q      <= bus.reqWrite;
                        addr_q       <= bus.reqAddress;
                        data_q       <= bus.writeData;
                        counter      <= CW'(LATENCY - 1);
                        state        <= (LATENCY == 1) ? RESP : WAIT;
                        bus.reqReady <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (counter == '0) state <= RESP;
                    else               counter <= counter - CW'(1);
                end
                RESP: begin
                    state        <= IDLE;
                    bus.reqReady <= 1'b1;
                    bus.busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (fire) begin
                bus.respValid <= 1'b1;
                if (!cur_write) begin
                    bus.dataOut  <= rd_word;
                    bus.blockOut <= blk_rd;
                end
            end
        end
    end
endmodule

// File: tb/tb_block_data_memory.sv
// Bench for block_data_memory: edge-counting reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_block_data_memory;
    localparam int WORD     = 32;
    localparam int ADDRESSL = 15;
    localparam int BW       = 4;
    localparam int LAT      = 4;
    localparam int LENGTH   = 1 << ADDRESSL;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    block_data_memory_if #(.WORD(WORD), .ADDRESSL(ADDRESSL), .BLOCK_WORDS(BW)) bus();

    block_data_memory #(.WORD(WORD), .ADDRESSL(ADDRESSL), .BLOCK_WORDS(BW), .LATENCY(LAT)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [BW*WORD-1:0] act, input logic [BW*WORD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request takes LAT edges to respond and one more to free the block.
    logic [WORD-1:0]          mdl_mem [LENGTH];
    int                       m_left    = 0;
    logic                     m_wr      = 1'b0;
    logic [ADDRESSL-1:0]      m_addr    = '0;
    logic [WORD-1:0]          m_wdata   = '0;
    logic                     exp_resp  = 1'b0;
    logic [WORD-1:0]          exp_data  = '0;
    logic [BW-1:0][WORD-1:0]  exp_block = '0;

    initial begin
        for (int i = 0; i < LENGTH; i++) mdl_mem[i] = WORD'(i);
        forever begin
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                m_left = 0; exp_resp = 1'b0; exp_data = '0; exp_block = '0;
            end else begin
                exp_resp = 1'b0;
                if (m_left == 0) begin
                    if (bus.reqValid) begin
                        m_wr = bus.reqWrite; m_addr = bus.reqAddress; m_wdata = bus.writeData;
                        m_left = LAT + 1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 1) begin
                        exp_resp = 1'b1;
                        if (m_wr) mdl_mem[m_addr] = m_wdata;
                        else begin
                            exp_data = mdl_mem[m_addr];
                            for (int k = 0; k < BW; k++)
                                exp_block[k] = mdl_mem[(int'(m_addr) / BW) * BW + k];
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstN) begin
                chk("reqReady",  bus.reqReady,  m_left == 0);
                chk("respValid", bus.respValid, exp_resp);
                chk("busy",      bus.busy,      m_left != 0);
                chk("dataOut",   bus.dataOut,   exp_data);
                chk("blockOut",  bus.blockOut,  exp_block);
            end
        end
    end

    task automatic send(input logic w, input logic [ADDRESSL-1:0] a, input logic [WORD-1:0] d);
        int n;
        @(negedge clk);
        bus.reqValid = 1'b1; bus.reqWrite = w; bus.reqAddress = a; bus.writeData = d;
        n = 0;
        while (!bus.reqReady && n < 20) begin @(negedge clk); n++; end
        chk("accept_timeout", n < 20, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0; bus.reqAddress = ~a; bus.writeData = ~d;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!bus.respValid && n < 20) begin @(negedge clk); n++; end
    endtask

    int n;
    int pulses;

    initial begin
        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqAddress = '0; bus.writeData = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.reqReady, 1'b1);
        chk("rst_resp",  bus.respValid, 1'b0);
        chk("rst_busy",  bus.busy, 1'b0);
        chk("rst_data",  bus.dataOut, '0);
        chk("rst_block", bus.blockOut, '0);

        // Plain read with latency check
        send(1'b0, 15'd5, '0);
        wait_resp(n);
        chk("rd5_lat", n, LAT);
        chk("rd5_ready_low", bus.reqReady, 1'b0);
        chk("rd5_data", bus.dataOut, 32'd5);
        chk("rd5_block", bus.blockOut, {32'd7, 32'd6, 32'd5, 32'd4});
        @(negedge clk);
        chk("rd5_ready_back", bus.reqReady, 1'b1);
        chk("rd5_resp_once", bus.respValid, 1'b0);

        // Write then read-after-write
        send(1'b1, 15'd6, 32'hDEADBEEF);
        wait_resp(n);
        chk("wr6_lat", n, LAT);
        chk("wr6_data_held", bus.dataOut, 32'd5);
        send(1'b0, 15'd6, '0);
        wait_resp(n);
        chk("raw6_data", bus.dataOut, 32'hDEADBEEF);
        chk("raw6_block", bus.blockOut, {32'd7, 32'hDEADBEEF, 32'd5, 32'd4});

        // Top of memory
        send(1'b0, 15'd32767, '0);
        wait_resp(n);
        chk("top_data", bus.dataOut, 32'd32767);
        chk("top_block", bus.blockOut, {32'd32767, 32'd32766, 32'd32765, 32'd32764});

        // reqValid held across two reads; address changes in WAIT ignored
        @(negedge clk);
        bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqAddress = 15'd1;
        n = 0;
        while (!bus.reqReady && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.reqAddress = 15'd9;
        wait_resp(n);
        chk("held1_data", bus.dataOut, 32'd1);
        @(negedge clk);
        chk("held_ready", bus.reqReady, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0; bus.reqAddress = 15'd3;
        wait_resp(n);
        chk("held9_lat", n, LAT);
        chk("held9_data", bus.dataOut, 32'd9);
        chk("held9_block", bus.blockOut, {32'd11, 32'd10, 32'd9, 32'd8});

        // Reset mid-write discards the write and suppresses the ack
        send(1'b1, 15'd10, 32'h1234);
        @(posedge clk);
        @(posedge clk);
        #2 rstN = 1'b0;
        #6 rstN = 1'b1;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (bus.respValid) pulses++; end
        chk("rst_no_ack", pulses, 0);
        send(1'b0, 15'd10, '0);
        wait_resp(n);
        chk("rst_wr_discard", bus.dataOut, 32'd10);
        chk("rst_wr_block", bus.blockOut, {32'd11, 32'd10, 32'd9, 32'd8});

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
